// File: rtl/gpu_sched_pkg.sv
// Shared command encoding, field positions and issue-FSM state type
// for the GPU command scheduler.
package gpu_sched_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned XY_W   = 3;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned X_LSB  = 3;
    localparam int unsigned Y_LSB  = 0;

    localparam logic [OP_W-1:0] OP_NOP   = 2'b00;
    localparam logic [OP_W-1:0] OP_SET   = 2'b01;
    localparam logic [OP_W-1:0] OP_CLR   = 2'b10;
    localparam logic [OP_W-1:0] OP_CLEAR = 2'b11;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XY_W-1:0] x;
        logic [XY_W-1:0] y;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Split a raw host command byte into its fields.
    function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
        cmd_t c;
        c.op = raw[OP_LSB +: OP_W];
        c.x  = raw[X_LSB +: XY_W];
        c.y  = raw[Y_LSB +: XY_W];
        return c;
    endfunction

endpackage

// File: rtl/gpu_cmd_scheduler_if.sv
// Requester handshakes, graphics-processor issue bus and host status
// for the GPU command scheduler.
interface gpu_cmd_scheduler_if #(
    parameter int unsigned DEPTH = 4
) ();
    import gpu_sched_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             req0_valid;
    logic [CMD_W-1:0] req0_cmd;
    logic             req0_ready;
    logic             req1_valid;
    logic [CMD_W-1:0] req1_cmd;
    logic             req1_ready;
    logic             frame_start;
    logic [OP_W-1:0]  gpu_command;
    logic [XY_W-1:0]  gpu_x;
    logic [XY_W-1:0]  gpu_y;
    logic             gpu_valid;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output req0_valid, req0_cmd, req1_valid, req1_cmd, frame_start,
        input  req0_ready, req1_ready, gpu_command, gpu_x, gpu_y, gpu_valid,
               busy, fifo_level
    );

    modport slave (
        input  req0_valid, req0_cmd, req1_valid, req1_cmd, frame_start,
        output req0_ready, req1_ready, gpu_command, gpu_x, gpu_y, gpu_valid,
               busy, fifo_level
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally since DEPTH is a power of 2.
module cmd_fifo
    import gpu_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     wdata,
    output cmd_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Round-robin arbitration of two command sources into a FIFO, and an
// issue FSM that strobes one command at a time followed by its busy window.
module gpu_cmd_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PIXEL_CYCLES = 1,
    parameter int unsigned CLEAR_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    gpu_cmd_scheduler_if.slave   bus
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > PIXEL_CYCLES) ? CLEAR_CYCLES : PIXEL_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;

    logic             rr;
    logic             ready0;
    logic             ready1;
    logic             grant0;
    logic             grant1;
    cmd_t             win_cmd;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    cmd_t             head;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_d;
    cmd_t             cur;

    // Ready terms look only at the other requester's valid, never their own.
    assign ready0  = !full && (!bus.req1_valid || !rr);
    assign ready1  = !full && (!bus.req0_valid ||  rr);
    assign grant0  = bus.req0_valid && ready0;
    assign grant1  = bus.req1_valid && ready1;
    assign win_cmd = grant0 ? unpack_cmd(bus.req0_cmd) : unpack_cmd(bus.req1_cmd);
    assign push    = (grant0 || grant1) && (win_cmd.op != OP_NOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr <= 1'b0;
        else if (grant0) rr <= 1'b1;
        else if (grant1) rr <= 1'b0;
    end

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (win_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cur           <= '0;
            bus.gpu_valid <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bus.gpu_valid <= valid_d;
            if (pop) cur <= head;
        end
    end

    // frame_start only blocks the launch decision; a running window ignores it.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pop     = 1'b0;
        valid_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !bus.frame_start) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                case (cur.op)
                    OP_CLEAR:       cnt_d = CNT_W'(CLEAR_CYCLES - 1);
                    OP_SET, OP_CLR: cnt_d = CNT_W'(PIXEL_CYCLES - 1);
                    default:        cnt_d = CNT_W'(PIXEL_CYCLES - 1);
                endcase
            end
            ST_WAIT: begin
                if (cnt == '0) state_d = ST_IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.gpu_command = cur.op;
    assign bus.gpu_x       = cur.x;
    assign bus.gpu_y       = cur.y;
    assign bus.fifo_level  = level;
    assign bus.busy        = (state != ST_IDLE) || (level != '0);

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Directed bench for gpu_cmd_scheduler: hand-computed issue timing,
// arbitration order, back-pressure, frame inhibit and reset behaviour.
module tb_gpu_cmd_scheduler;
    import gpu_sched_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   iss_cyc [$];
    logic [7:0] iss_cmd [$];

    gpu_cmd_scheduler_if #(.DEPTH(DEPTH)) bus ();

    gpu_cmd_scheduler #(.DEPTH(DEPTH), .PIXEL_CYCLES(1), .CLEAR_CYCLES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every issue strobe with its edge number and payload.
    initial cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.gpu_valid === 1'b1) begin
            iss_cyc.push_back(cyc);
            iss_cmd.push_back({bus.gpu_command, bus.gpu_x, bus.gpu_y});
        end
    end

    function automatic logic [7:0] pix(input int i);
        return {2'b01, 3'(i), 3'(i)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid  = 1'b0;
        bus.req0_cmd    = 8'h00;
        bus.req1_valid  = 1'b0;
        bus.req1_cmd    = 8'h00;
        bus.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        iss_cyc.delete();
        iss_cmd.delete();
    endtask

    task automatic wait_issues(input int n, input int limit);
        for (int i = 0; i < limit && iss_cyc.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.gpu_valid, bus.gpu_command, bus.gpu_x, bus.gpu_y} !== 9'h0) begin
            bad++; $display("FAIL reset_gpu: got %0h want 0", {bus.gpu_valid, bus.gpu_command, bus.gpu_x, bus.gpu_y});
        end
        total++;
        if (bus.fifo_level !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_status: level=%0d busy=%b want 0 0", bus.fifo_level, bus.busy);
        end
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b%b want 11", bus.req0_ready, bus.req1_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_cmd = 8'h5D;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        total++;
        if (bus.gpu_valid !== 1'b0 || bus.fifo_level !== 3'd1) begin
            bad++; $display("FAIL single_c1: valid=%b level=%0d want 0 1", bus.gpu_valid, bus.fifo_level);
        end
        @(negedge clk);
        total++;
        if (bus.gpu_valid !== 1'b1 || {bus.gpu_command, bus.gpu_x, bus.gpu_y} !== 8'h5D || bus.fifo_level !== 3'd0) begin
            bad++; $display("FAIL single_issue: valid=%b cmd=%h level=%0d want 1 5d 0",
                            bus.gpu_valid, {bus.gpu_command, bus.gpu_x, bus.gpu_y}, bus.fifo_level);
        end
        @(negedge clk);
        total++;
        if (bus.gpu_valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_c3: valid=%b busy=%b want 0 1", bus.gpu_valid, bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || {bus.gpu_command, bus.gpu_x, bus.gpu_y} !== 8'h5D || iss_cyc.size() != 1) begin
            bad++; $display("FAIL single_c4: busy=%b cmd=%h issues=%0d want 0 5d 1",
                            bus.busy, {bus.gpu_command, bus.gpu_x, bus.gpu_y}, iss_cyc.size());
        end
    endtask

    task automatic test_contention();
        logic exp0;
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_cmd = 8'h49;
        bus.req1_valid = 1'b1; bus.req1_cmd = 8'h52;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp0 = (i % 2 == 0);
            total++;
            if (bus.req0_ready !== exp0 || bus.req1_ready !== !exp0) begin
                bad++; $display("FAIL contention_grant%0d: ready=%b%b want %b%b",
                                i, bus.req0_ready, bus.req1_ready, exp0, !exp0);
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_issues(4, 40);
        total++;
        if (iss_cyc.size() != 4) begin
            bad++; $display("FAIL contention_count: got %0d want 4", iss_cyc.size());
        end else if (iss_cmd[0] !== 8'h49 || iss_cmd[1] !== 8'h52 || iss_cmd[2] !== 8'h49 || iss_cmd[3] !== 8'h52) begin
            bad++; $display("FAIL contention_order: got %h %h %h %h want 49 52 49 52",
                            iss_cmd[0], iss_cmd[1], iss_cmd[2], iss_cmd[3]);
        end
    endtask

    task automatic test_full();
        do_reset();
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_cmd = pix(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req0_cmd = pix(i + 1);
        end
        total++;
        if (bus.fifo_level !== 3'd4 || bus.req0_ready !== 1'b0) begin
            bad++; $display("FAIL full_reach: level=%0d ready=%b want 4 0", bus.fifo_level, bus.req0_ready);
        end
        repeat (2) @(negedge clk);
        total++;
        if (bus.fifo_level !== 3'd4 || bus.req0_ready !== 1'b0 || iss_cyc.size() != 0) begin
            bad++; $display("FAIL full_hold: level=%0d ready=%b issues=%0d want 4 0 0",
                            bus.fifo_level, bus.req0_ready, iss_cyc.size());
        end
        bus.frame_start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.fifo_level !== 3'd3 || bus.req0_ready !== 1'b1 || bus.gpu_valid !== 1'b1) begin
            bad++; $display("FAIL full_pop: level=%0d ready=%b valid=%b want 3 1 1",
                            bus.fifo_level, bus.req0_ready, bus.gpu_valid);
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        total++;
        if (bus.fifo_level !== 3'd4) begin
            bad++; $display("FAIL full_fifth: level=%0d want 4", bus.fifo_level);
        end
        wait_issues(5, 40);
        total++;
        if (iss_cyc.size() != 5) begin
            bad++; $display("FAIL full_count: got %0d want 5", iss_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (iss_cmd[i] !== pix(i) || (i > 0 && iss_cyc[i] - iss_cyc[i-1] != 3)) begin
                    bad++; $display("FAIL full_issue%0d: cmd=%h gap=%0d want %h 3",
                                    i, iss_cmd[i], (i > 0) ? iss_cyc[i] - iss_cyc[i-1] : 3, pix(i));
                end
            end
        end
    endtask

    task automatic test_clear_frame();
        logic busy_ok;
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_cmd = 8'hC0;
        @(negedge clk);
        bus.req0_cmd = 8'h5D;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 150 && iss_cyc.size() < 2; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        total++;
        if (iss_cyc.size() != 2) begin
            bad++; $display("FAIL clear_count: got %0d want 2", iss_cyc.size());
        end else if (iss_cyc[1] - iss_cyc[0] != 66 || iss_cmd[0] !== 8'hC0 || iss_cmd[1] !== 8'h5D) begin
            bad++; $display("FAIL clear_gap: gap=%0d cmds=%h %h want 66 c0 5d",
                            iss_cyc[1] - iss_cyc[0], iss_cmd[0], iss_cmd[1]);
        end
        total++;
        if (busy_ok !== 1'b1) begin
            bad++; $display("FAIL clear_busy: got %b want 1", busy_ok);
        end
    endtask

    task automatic test_frame_start_nop();
        int n;
        do_reset();
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_cmd = 8'h5D;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (iss_cyc.size() != 0 || bus.fifo_level !== 3'd1) begin
            bad++; $display("FAIL frame_inhibit: issues=%0d level=%0d want 0 1", iss_cyc.size(), bus.fifo_level);
        end
        bus.frame_start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.gpu_valid !== 1'b1 || iss_cyc.size() != 1) begin
            bad++; $display("FAIL frame_release: valid=%b issues=%0d want 1 1", bus.gpu_valid, iss_cyc.size());
        end
        repeat (3) @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_cmd = 8'h00;
        #1;
        total++;
        if (bus.req1_ready !== 1'b1) begin
            bad++; $display("FAIL nop_ready: got %b want 1", bus.req1_ready);
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        total++;
        if (bus.fifo_level !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL nop_level: level=%0d busy=%b want 0 0", bus.fifo_level, bus.busy);
        end
        bus.req0_valid = 1'b1; bus.req0_cmd = 8'h49;
        bus.req1_valid = 1'b1; bus.req1_cmd = 8'h52;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL nop_rr: ready=%b%b want 10", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        n = iss_cyc.size();
        repeat (6) @(negedge clk);
        total++;
        if (iss_cyc.size() != n) begin
            bad++; $display("FAIL nop_issue: issues=%0d want %0d", iss_cyc.size(), n);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_cmd = 8'hC0;
        @(negedge clk);
        bus.req0_cmd = 8'h5D;
        @(negedge clk);
        bus.req0_cmd = 8'h64;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (bus.fifo_level !== 3'd2 || bus.gpu_command !== 2'b11 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL areset_pre: level=%0d cmd=%b busy=%b want 2 11 1",
                            bus.fifo_level, bus.gpu_command, bus.busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.gpu_valid, bus.gpu_command, bus.gpu_x, bus.gpu_y} !== 9'h0 || bus.fifo_level !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL areset_now: gpu=%h level=%0d busy=%b want 0 0 0",
                            {bus.gpu_valid, bus.gpu_command, bus.gpu_x, bus.gpu_y}, bus.fifo_level, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        iss_cyc.delete();
        iss_cmd.delete();
        repeat (100) @(negedge clk);
        total++;
        if (iss_cyc.size() != 0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL areset_stale: issues=%0d busy=%b want 0 0", iss_cyc.size(), bus.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_clear_frame();
        test_frame_start_nop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
